ren_conv_wb_regs: RTL and testbench

//   Wishbone B4 classic slave front-end for one ren_conv accelerator instance; responder side of the host/Caravel bus.

---
 rtl/ren_conv_pkg.sv | 55 +++++
 rtl/ren_conv_wb_decode.sv | 22 ++
 rtl/ren_conv_wb_regs.sv | 193 +++++++++++++++++++
 tb/tb_ren_conv_wb_regs.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ren_conv_pkg.sv
// Shared definitions for the ren_conv Wishbone front-end: address map, register layout and FSM encoding.
package ren_conv_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h3000_0000;
  localparam logic [5:0]  BASE_TAG  = BASE_ADDR[31:26];

  typedef enum logic [1:0] {
    RGN_REG  = 2'd0,
    RGN_IMG  = 2'd1,
    RGN_KERN = 2'd2,
    RGN_RES  = 2'd3
  } region_e;

  localparam logic [7:0] REG0_OFS = 8'h00;
  localparam logic [7:0] REG1_OFS = 8'h04;
  localparam logic [7:0] REG2_OFS = 8'h08;
  localparam logic [5:0] REG0_IDX = REG0_OFS[7:2];
  localparam logic [5:0] REG1_IDX = REG1_OFS[7:2];
  localparam logic [5:0] REG2_IDX = REG2_OFS[7:2];

  localparam int DONE_BIT   = 0;
  localparam int SOFT_BIT   = 1;
  localparam int START_BIT  = 2;
  localparam int IRQ_EN_BIT = 3;

  localparam int KERN_COLS_LSB = 0;  localparam int KERN_COLS_W = 3;
  localparam int COLS_LSB      = 8;  localparam int COLS_W      = 8;
  localparam int KERNS_LSB     = 16; localparam int KERNS_W     = 3;
  localparam int STRIDE_LSB    = 24; localparam int STRIDE_W    = 8;

  localparam int RCOLS_LSB = 0;  localparam int RCOLS_W = 8;
  localparam int SHIFT_LSB = 8;  localparam int SHIFT_W = 4;
  localparam int KAM_BIT   = 16;
  localparam int EMP_BIT   = 17;
  localparam int MASK_LSB  = 18; localparam int MASK_W  = 3;

  // Writable bits of each register; everything else reads back as 0.
  localparam logic [31:0] REG0_RW_BITS = 32'h0000_000E;
  localparam logic [31:0] REG1_MASK    = 32'hFF07_FF07;
  localparam logic [31:0] REG2_MASK    = 32'h001F_0FFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_e;

  function automatic logic [31:0] apply_sel(input logic [31:0] cur, input logic [31:0] wdat,
                                            input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = sel[b] ? wdat[b*8 +: 8] : cur[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/ren_conv_wb_decode.sv
// Combinational address decode: instance hit, region and word index from the Wishbone request.
module ren_conv_wb_decode
  import ren_conv_pkg::*;
#(
  parameter int INST_ID = 0
) (
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [31:0] adr_i,
  output logic        hit_o,
  output region_e     region_o,
  output logic [5:0]  word_idx_o
);

  logic unused_adr;

  assign hit_o      = cyc_i & stb_i & (adr_i[31:26] == BASE_TAG) & (adr_i[25:24] == 2'(INST_ID));
  assign region_o   = region_e'(adr_i[9:8]);
  assign word_idx_o = adr_i[7:2];
  assign unused_adr = &{1'b0, adr_i[23:10], adr_i[1:0]};

endmodule

// File: rtl/ren_conv_wb_regs.sv
// Wishbone B4 classic slave for one ren_conv instance: config/control registers, sticky done, memory forwarding.
// Ack one cycle after a write/REG read, two after a RES read; define REN_CONV_IRQ_EN to add irq_o and reg0[3].
module ren_conv_wb_regs
  import ren_conv_pkg::*;
#(
  parameter int INST_ID         = 0,
  parameter int IMG_ADDR_WIDTH  = 6,
  parameter int RSLT_ADDR_WIDTH = 6,
  parameter int RSLT_DWIDTH     = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_dat_i,
  input  logic [31:0]               wbs_adr_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic [IMG_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [23:0]               mem_wdata_o,
  output logic                      img_we_o,
  output logic                      kern_we_o,
  output logic                      res_re_o,
  input  logic [RSLT_DWIDTH-1:0]    res_rdata_i,
  input  logic                      done_i,
`ifdef REN_CONV_IRQ_EN
  output logic                      irq_o,
`endif
  output logic                      start_o,
  output logic                      start_pulse_o,
  output logic                      soft_rst_o,
  output logic [2:0]                cfg_kern_cols_o,
  output logic [7:0]                cfg_cols_o,
  output logic [2:0]                cfg_kerns_o,
  output logic [7:0]                cfg_stride_o,
  output logic [7:0]                cfg_result_cols_o,
  output logic [3:0]                cfg_shift_o,
  output logic                      cfg_kern_addr_mode_o,
  output logic                      cfg_en_max_pool_o,
  output logic [2:0]                cfg_mask_o
);

`ifdef REN_CONV_IRQ_EN
  localparam logic [31:0] REG0_WMASK = REG0_RW_BITS;
`else
  localparam logic [31:0] REG0_WMASK = REG0_RW_BITS & ~(32'd1 << IRQ_EN_BIT);
`endif

  logic       hit;
  region_e    region;
  logic [5:0] word_idx;

  ren_conv_wb_decode #(.INST_ID(INST_ID)) u_decode (
    .cyc_i      (wbs_cyc_i),
    .stb_i      (wbs_stb_i),
    .adr_i      (wbs_adr_i),
    .hit_o      (hit),
    .region_o   (region),
    .word_idx_o (word_idx)
  );

  state_e      state_q, state_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
  logic        done_q, done_d;
  logic        start_pulse_q, start_pulse_d;
  logic        done_clr;
  logic [31:0] reg_rdata;

  always_comb begin
    reg_rdata = '0;
    case (word_idx)
      REG0_IDX: begin
        reg_rdata           = reg0_q;
        reg_rdata[DONE_BIT] = done_q;
      end
      REG1_IDX: reg_rdata = reg1_q;
      REG2_IDX: reg_rdata = reg2_q;
      default:  reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    dat_d         = dat_q;
    reg0_d        = reg0_q;
    reg1_d        = reg1_q;
    reg2_d        = reg2_q;
    start_pulse_d = 1'b0;
    done_clr      = 1'b0;
    img_we_o      = 1'b0;
    kern_we_o     = 1'b0;
    res_re_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Reset masks the request so a transaction overlapping reset leaves no side effects.
        if (hit && !wb_rst_i) begin
          if (wbs_we_i) begin
            state_d = ST_ACK;
            dat_d   = '0;
            case (region)
              RGN_REG: begin
                case (word_idx)
                  REG0_IDX: begin
                    reg0_d        = apply_sel(reg0_q, wbs_dat_i, wbs_sel_i) & REG0_WMASK;
                    start_pulse_d = reg0_d[START_BIT] & ~reg0_q[START_BIT];
                    done_clr      = reg0_d[SOFT_BIT] | start_pulse_d;
                  end
                  REG1_IDX: reg1_d = apply_sel(reg1_q, wbs_dat_i, wbs_sel_i) & REG1_MASK;
                  REG2_IDX: reg2_d = apply_sel(reg2_q, wbs_dat_i, wbs_sel_i) & REG2_MASK;
                  default: ;
                endcase
              end
              RGN_IMG:  img_we_o  = 1'b1;
              RGN_KERN: kern_we_o = 1'b1;
              default: ;
            endcase
          end else if (region == RGN_RES) begin
            state_d  = ST_RD_WAIT;
            res_re_o = 1'b1;
          end else begin
            state_d = ST_ACK;
            dat_d   = (region == RGN_REG) ? reg_rdata : '0;
          end
        end
      end
      ST_RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
          dat_d   = 32'(res_rdata_i);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A clearing write wins over a coincident done pulse.
    done_d = done_clr ? 1'b0 : (done_i | done_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      dat_q         <= '0;
      reg0_q        <= '0;
      reg1_q        <= '0;
      reg2_q        <= '0;
      done_q        <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dat_q         <= dat_d;
      reg0_q        <= reg0_d;
      reg1_q        <= reg1_d;
      reg2_q        <= reg2_d;
      done_q        <= done_d;
      start_pulse_q <= start_pulse_d;
    end
  end

`ifdef REN_CONV_IRQ_EN
  logic irq_q, irq_d;
  always_comb irq_d = done_d & reg0_d[IRQ_EN_BIT];
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`endif

  assign wbs_ack_o     = (state_q == ST_ACK);
  assign wbs_dat_o     = dat_q;
  assign mem_addr_o    = (region == RGN_RES) ? IMG_ADDR_WIDTH'(RSLT_ADDR_WIDTH'(word_idx))
                                             : IMG_ADDR_WIDTH'(word_idx);
  assign mem_wdata_o   = wbs_dat_i[23:0];
  assign start_o       = reg0_q[START_BIT];
  assign start_pulse_o = start_pulse_q;
  assign soft_rst_o    = reg0_q[SOFT_BIT] | wb_rst_i;

  assign cfg_kern_cols_o      = reg1_q[KERN_COLS_LSB +: KERN_COLS_W];
  assign cfg_cols_o           = reg1_q[COLS_LSB +: COLS_W];
  assign cfg_kerns_o          = reg1_q[KERNS_LSB +: KERNS_W];
  assign cfg_stride_o         = reg1_q[STRIDE_LSB +: STRIDE_W];
  assign cfg_result_cols_o    = reg2_q[RCOLS_LSB +: RCOLS_W];
  assign cfg_shift_o          = reg2_q[SHIFT_LSB +: SHIFT_W];
  assign cfg_kern_addr_mode_o = reg2_q[KAM_BIT];
  assign cfg_en_max_pool_o    = reg2_q[EMP_BIT];
  assign cfg_mask_o           = reg2_q[MASK_LSB +: MASK_W];

endmodule

// File: tb/tb_ren_conv_wb_regs.sv
// Directed bench for ren_conv_wb_regs with INST_ID=1 and a result memory returning word index + 0x40.
module tb_ren_conv_wb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic [5:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        img_we, kern_we, res_re;
  logic [7:0]  res_rdata;
  logic        done_in;
  logic        start, start_pulse, soft_rst;
  logic [2:0]  kern_cols, kerns, mask;
  logic [7:0]  cols, stride, result_cols;
  logic [3:0]  shift;
  logic        kam, emp;
`ifdef REN_CONV_IRQ_EN
  logic        irq;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic        s_img_we, s_kern_we, s_res_re, s_start_pulse, s_post_we;
  logic [5:0]  s_mem_addr;
  logic [23:0] s_mem_wdata;
  int          lat;
  logic [31:0] rd;

  always #5 clk = ~clk;

  always @(posedge clk) if (res_re) res_rdata <= {2'b00, mem_addr} + 8'h40;

  ren_conv_wb_regs #(
    .INST_ID(1), .IMG_ADDR_WIDTH(6), .RSLT_ADDR_WIDTH(6), .RSLT_DWIDTH(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .img_we_o(img_we), .kern_we_o(kern_we), .res_re_o(res_re), .res_rdata_i(res_rdata),
    .done_i(done_in),
`ifdef REN_CONV_IRQ_EN
    .irq_o(irq),
`endif
    .start_o(start), .start_pulse_o(start_pulse), .soft_rst_o(soft_rst),
    .cfg_kern_cols_o(kern_cols), .cfg_cols_o(cols), .cfg_kerns_o(kerns), .cfg_stride_o(stride),
    .cfg_result_cols_o(result_cols), .cfg_shift_o(shift), .cfg_kern_addr_mode_o(kam),
    .cfg_en_max_pool_o(emp), .cfg_mask_o(mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; holds the request until ack or an 8-cycle budget, then leaves one idle cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic dn, output int l, output logic [31:0] r);
    logic got;
    got = 1'b0; l = -1; r = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; done_in = dn;
    #1;
    s_img_we = img_we; s_kern_we = kern_we; s_res_re = res_re;
    s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk); #1;
      done_in = 1'b0;
      if (ack) begin
        got = 1'b1; l = i; r = dat_o;
        s_start_pulse = start_pulse; s_post_we = img_we | kern_we;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = '0; adr = '0; done_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_soft_rst_hi", soft_rst, 1);
    chk("rst_start", start, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("soft_rst_released", soft_rst, 0);

    // 1: reg1 write, then a write addressed to another instance
    wb_xfer(1, 32'h3100_0004, 32'h0102_0701, 4'hF, 0, lat, rd);
    chk("reg1_lat", lat, 1);
    chk("kern_cols", kern_cols, 1);
    chk("cols", cols, 7);
    chk("kerns", kerns, 2);
    chk("stride", stride, 1);
    wb_xfer(1, 32'h3000_0004, 32'h0102_0701, 4'hF, 0, lat, rd);
    chk("miss_no_ack", lat, -1);
    chk("miss_cols", cols, 7);
    wb_xfer(1, 32'h3100_0004, 32'hFFFF_FFFF, 4'b0010, 0, lat, rd);
    chk("sel_lane1_cols", cols, 8'hFF);
    chk("sel_lane0_kept", kern_cols, 1);
    chk("sel_lane3_kept", stride, 1);

    // 2: reg2 write and readback
    wb_xfer(1, 32'h3100_0008, 32'h001E_0C0B, 4'hF, 0, lat, rd);
    chk("result_cols", result_cols, 11);
    chk("shift", shift, 12);
    chk("kern_addr_mode", kam, 0);
    chk("en_max_pool", emp, 1);
    chk("mask", mask, 7);
    wb_xfer(0, 32'h3100_0008, 32'h0, 4'hF, 0, lat, rd);
    chk("reg2_rd_lat", lat, 1);
    chk("reg2_rd", rd, 32'h001E_0C0B);
    wb_xfer(0, 32'h3100_0014, 32'h0, 4'hF, 0, lat, rd);
    chk("reg5_rd_zero", rd, 0);
    wb_xfer(0, 32'h3100_0104, 32'h0, 4'hF, 0, lat, rd);
    chk("img_rd_lat", lat, 1);
    chk("img_rd_zero", rd, 0);

    // 3: memory writes
    wb_xfer(1, 32'h3100_0114, 32'h00AA_BBCC, 4'h0, 0, lat, rd);
    chk("img_we", s_img_we, 1);
    chk("img_kern_we_off", s_kern_we, 0);
    chk("img_addr", s_mem_addr, 5);
    chk("img_wdata", s_mem_wdata, 24'hAABBCC);
    chk("img_we_pulse_end", s_post_we, 0);
    wb_xfer(1, 32'h3100_0214, 32'h00AA_BBCC, 4'hF, 0, lat, rd);
    chk("kern_we", s_kern_we, 1);
    chk("kern_img_we_off", s_img_we, 0);
    chk("kern_addr", s_mem_addr, 5);

    // 4: start, done, soft reset
    wb_xfer(1, 32'h3100_0000, 32'h4, 4'hF, 0, lat, rd);
    chk("start_pulse", s_start_pulse, 1);
    chk("start_pulse_gone", start_pulse, 0);
    chk("start_level", start, 1);
    wb_xfer(0, 32'h3100_0000, 32'h0, 4'hF, 1, lat, rd);
    chk("reg0_rd_pre_done", rd, 32'h4);
    wb_xfer(0, 32'h3100_0000, 32'h0, 4'hF, 0, lat, rd);
    chk("reg0_rd_done", rd, 32'h5);
    wb_xfer(1, 32'h3100_0000, 32'h8, 4'hF, 0, lat, rd);
    wb_xfer(0, 32'h3100_0000, 32'h0, 4'hF, 0, lat, rd);
`ifdef REN_CONV_IRQ_EN
    chk("reg0_irq_en_rd", rd, 32'h9);
`else
    chk("reg0_irq_en_ignored", rd, 32'h1);
`endif
    wb_xfer(1, 32'h3100_0000, 32'h2, 4'hF, 1, lat, rd);
    chk("soft_rst_set", soft_rst, 1);
    wb_xfer(0, 32'h3100_0000, 32'h0, 4'hF, 0, lat, rd);
    chk("done_clr_beats_set", rd, 32'h2);
    wb_xfer(1, 32'h3100_0000, 32'h0, 4'hF, 0, lat, rd);
    chk("soft_rst_clr", soft_rst, 0);

    // 5: result read
    wb_xfer(0, 32'h3100_030C, 32'h0, 4'hF, 0, lat, rd);
    chk("res_re", s_res_re, 1);
    chk("res_addr", s_mem_addr, 3);
    chk("res_lat", lat, 2);
    chk("res_dat", rd, 32'h43);

    // cyc dropped while waiting on the result memory
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0304;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("cyc_drop_no_ack", ack, 0);
      @(posedge clk); #1;
    end

    // 6: reset while in RD_WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0304;
    @(posedge clk); #1;
    chk("rdwait_no_ack", ack, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdwait_ack", ack, 0);
    chk("rst_rdwait_dat", dat_o, 0);
    chk("rst_result_cols", result_cols, 0);
    chk("rst_cols", cols, 0);
    chk("rst_res_re", res_re, 0);
    chk("rst_soft_rst", soft_rst, 1);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_ack", ack, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ack", ack, 0);
    wb_xfer(1, 32'h3100_0008, 32'h0000_0A05, 4'hF, 0, lat, rd);
    chk("post_rst_wr_lat", lat, 1);
    wb_xfer(0, 32'h3100_0008, 32'h0, 4'hF, 0, lat, rd);
    chk("post_rst_rd", rd, 32'h0000_0A05);

`ifdef REN_CONV_IRQ_EN
    wb_xfer(1, 32'h3100_0000, 32'h8, 4'hF, 0, lat, rd);
    chk("irq_idle", irq, 0);
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    chk("irq_set", irq, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
